// File: rtl/zpaq_rdata_byte_unpack.sv
// Unpacks 32-bit AXI read-data beats into a little-endian byte stream of a
// programmed length, with a completion pulse and a sticky read-error flag.
module zpaq_rdata_byte_unpack #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  byte_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [1:0]            s_resp,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [7:0]            m_byte,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [1:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Neither side's valid depends combinationally on its own ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [LEN_WIDTH-1:0]  words_left_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [1:0]            idx_q;
  logic                  full_q;
  logic                  err_q;

  logic                  byte_hs;
  logic                  beat_acc;
  logic                  rem_one;
  logic                  word_drain;
  logic [LEN_WIDTH-1:0]  words_init;

  // ceil(byte_len/4) without forming byte_len+3, so the maximum length cannot wrap.
  assign words_init = (byte_len >> 2) + LEN_WIDTH'(|byte_len[1:0]);

  assign rem_one    = (rem_q == LEN_WIDTH'(1));
  assign byte_hs    = m_valid && m_ready;
  assign word_drain = byte_hs && ((idx_q == 2'd3) || rem_one);
  assign s_ready    = (state_q == S_RUN) && (words_left_q != '0) && (!full_q || word_drain);
  assign beat_acc   = s_valid && s_ready;

  assign m_valid   = full_q;
  assign m_last    = full_q && rem_one;
  assign err       = err_q;
  assign dbg_state = state_q;

  always_comb begin
    m_byte = 8'h00;
    case (idx_q)
      2'd0:    m_byte = hold_q[7:0];
      2'd1:    m_byte = hold_q[15:8];
      2'd2:    m_byte = hold_q[23:16];
      default: m_byte = hold_q[31:24];
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (byte_len != '0) ? S_RUN : S_FIN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (byte_hs && rem_one) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rem_q        <= '0;
      words_left_q <= '0;
      hold_q       <= '0;
      idx_q        <= 2'd0;
      full_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        err_q  <= 1'b0;
        idx_q  <= 2'd0;
        full_q <= 1'b0;
        if (byte_len != '0) begin
          rem_q        <= byte_len;
          words_left_q <= words_init;
        end
      end
      // A beat accepted in the same cycle as the word's final byte reloads
      // the holding register, so there is no bubble between words.
      if (beat_acc) begin
        hold_q       <= s_data;
        idx_q        <= 2'd0;
        full_q       <= 1'b1;
        words_left_q <= words_left_q - LEN_WIDTH'(1);
        if (s_resp != 2'd0) begin
          err_q <= 1'b1;
        end
      end else if (byte_hs) begin
        idx_q <= idx_q + 2'd1;
        if (word_drain) begin
          full_q <= 1'b0;
        end
      end
      if (byte_hs) begin
        rem_q <= rem_q - LEN_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_zpaq_rdata_byte_unpack.sv
// Scoreboard bench for zpaq_rdata_byte_unpack: expected bytes come from a
// word/byte-index model of the programmed transfer and are checked by a monitor.
module tb_zpaq_rdata_byte_unpack;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic [31:0] byte_len = '0;
  logic        busy, done, err;
  logic [31:0] s_data;
  logic [1:0]  s_resp;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  m_byte;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  logic [8:0]  exp_q[$];   // {last, byte}
  logic [33:0] beat_q[$];  // {resp, data}
  logic [31:0] plan_w[$];
  logic [1:0]  plan_r[$];
  int          beats_acc = 0;
  int          byte_cnt = 0;
  int          ready_mode = 0;
  bit          gap_en = 1'b0;

  zpaq_rdata_byte_unpack #(.DATA_WIDTH(32), .LEN_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .byte_len(byte_len),
    .busy(busy), .done(done), .err(err),
    .s_data(s_data), .s_resp(s_resp), .s_valid(s_valid), .s_ready(s_ready),
    .m_byte(m_byte), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .dbg_state(dbg_state)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {busy, done, err, s_ready, m_valid, m_last, m_byte, dbg_state}, '0);
  endtask

  // Upstream beat driver: offers the head of beat_q, pops on acceptance.
  initial begin
    bit take;
    s_valid = 1'b0;
    s_data  = '0;
    s_resp  = '0;
    forever begin
      @(negedge ACLK);
      take = s_valid && s_ready;
      @(posedge ACLK);
      #1;
      if (take && beat_q.size() > 0) begin
        void'(beat_q.pop_front());
        beats_acc++;
      end
      if (beat_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
        s_valid = 1'b1;
        {s_resp, s_data} = beat_q[0];
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  // Downstream ready driver.
  initial begin
    int pat;
    pat = 0;
    m_ready = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      case (ready_mode)
        0: m_ready = 1'b1;
        1: begin m_ready = (pat % 3 == 0); pat++; end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: byte compare, stall stability, done-after-last.
  initial begin
    bit         stall_v;
    bit         pend_done;
    logic [8:0] stall_val;
    stall_v = 1'b0;
    pend_done = 1'b0;
    stall_val = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        stall_v = 1'b0;
        pend_done = 1'b0;
      end else begin
        if (pend_done) begin
          chk("done_after_last", done, 1);
          pend_done = 1'b0;
        end
        if (stall_v && m_valid) chk("stall_stable", {m_last, m_byte}, stall_val);
        if (m_valid && !m_ready) chk("s_ready_while_stalled", s_ready, 0);
        if (m_valid && m_ready) begin
          byte_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte actual=0x%0h required=none", m_byte);
          end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            chk("byte", {m_last, m_byte}, e);
            if (e[8]) pend_done = 1'b1;
          end
        end
        stall_v = m_valid && !m_ready;
        stall_val = {m_last, m_byte};
      end
    end
  end

  // Builds beats and the expected byte stream: byte i is byte (i%4) of word i/4.
  task automatic build(input int len, input int extra, output bit exp_err, output int nw);
    nw = (len + 3) / 4;
    exp_err = 1'b0;
    for (int w = 0; w < nw + extra; w++) begin
      logic [31:0] d;
      logic [1:0]  r;
      if (w < plan_w.size()) begin
        d = plan_w[w];
        r = plan_r[w];
      end else begin
        d = $urandom;
        r = (gap_en && $urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'd0;
      end
      if (w < nw && r != 2'd0) exp_err = 1'b1;
      beat_q.push_back({r, d});
      for (int b = 0; b < 4; b++) begin
        if (w * 4 + b < len) exp_q.push_back({1'(w * 4 + b == len - 1), d[8*b +: 8]});
      end
    end
    plan_w.delete();
    plan_r.delete();
  endtask

  task automatic pulse_start(input int len);
    @(posedge ACLK);
    #1;
    start = 1'b1;
    byte_len = len;
    @(posedge ACLK);
    #1;
    start = 1'b0;
    byte_len = $urandom;
  endtask

  task automatic xfer(input int len, input int mode, input int extra, input bit mid_start);
    bit exp_err;
    int nw;
    int base;
    bit done_seen;
    ready_mode = mode;
    build(len, extra, exp_err, nw);
    base = beats_acc;
    pulse_start(len);
    done_seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge ACLK);
      if (c == 0) chk("err_cleared_by_start", err, 0);
      if (done) begin
        done_seen = 1'b1;
        if (len == 0) chk("zero_len_done_cycle", c, 0);
        break;
      end
      if (mid_start && c == 4) begin
        start = 1'b1;
        byte_len = 4;
        @(posedge ACLK);
        #1;
        start = 1'b0;
      end
    end
    chk("done_seen", done_seen, 1);
    if (done_seen) begin
      chk("busy_at_done", busy, 0);
      chk("err_at_done", err, exp_err);
      chk("all_bytes_out", exp_q.size(), 0);
      chk("beats_accepted", beats_acc - base, nw);
      chk("extra_beats_left", beat_q.size(), extra);
      @(negedge ACLK);
      chk("done_one_cycle", {done, busy}, 0);
      chk("err_sticky", err, exp_err);
    end
    exp_q.delete();
    beat_q.delete();
  endtask

  initial begin
    bit unused_err;
    int unused_nw;
    int base;
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    chk_reset_outputs("reset_outputs");
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;

    // Aligned run.
    plan_w = '{32'h44332211, 32'h88776655};
    plan_r = '{2'd0, 2'd0};
    xfer(8, 0, 0, 0);

    // Unaligned tail with a surplus beat offered.
    plan_w = '{32'hDDCCBBAA, 32'h00FFEE99, 32'h12345678};
    plan_r = '{2'd0, 2'd0, 2'd0};
    xfer(5, 0, 1, 0);

    // Back-pressure 1,0,0 pattern.
    xfer(4, 1, 0, 0);

    // Zero length, with a beat offered that must not be taken.
    xfer(0, 0, 1, 0);

    // Start issued mid-run is ignored.
    xfer(12, 0, 0, 1);

    // Error response on the second beat, then the next start clears it.
    plan_w = '{32'h0BADF00D, 32'hCAFEBABE};
    plan_r = '{2'd0, 2'd2};
    xfer(8, 0, 0, 0);
    xfer(0, 0, 0, 0);

    // Reset mid-transfer.
    ready_mode = 0;
    build(8, 0, unused_err, unused_nw);
    base = byte_cnt;
    pulse_start(8);
    for (int c = 0; c < 100; c++) begin
      @(negedge ACLK);
      if (byte_cnt - base >= 3) break;
    end
    chk("bytes_before_reset", (byte_cnt - base >= 3), 1);
    #1;
    ARESETN = 1'b0;
    #1;
    chk_reset_outputs("async_reset_outputs");
    exp_q.delete();
    beat_q.delete();
    repeat (3) begin
      @(negedge ACLK);
      chk("no_done_in_reset", done, 0);
    end
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    xfer(4, 0, 0, 0);

    // Randomized transfers with gaps, random ready and random error responses.
    gap_en = 1'b1;
    for (int t = 0; t < 10; t++) begin
      xfer($urandom_range(1, 14), 2, $urandom_range(0, 1), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
